conv_window_ctrl: RTL
=====================

Name: conv_window_ctrl

Overview:
- Frame sequencer for the 3x3 sliding-window line memory and the filter pipeline behind it.
- On `start` it scans every window origin in raster order and asserts `rd` with the window row/column.
- It tracks in-flight pixels through the fixed-latency filter pipeline and asserts `wr` with the output row/column when each result emerges.
- It pulses `done` once the frame has fully drained.

Parameters:
- IMG_W, 64, window origins per row (columns scanned).
- IMG_H, 64, window origins per frame (rows scanned).
- AW, 7, width of all row/column address outputs; must satisfy 2^AW >= max(IMG_W, IMG_H).
- PIPE_LAT, 3, cycles from a `rd` cycle to the matching `wr` cycle; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin one frame; sampled only in IDLE.
- hold  in  1  pause read issue (back-pressure from downstream).
- rd  out  1  window read strobe to line memory.
- win_row  out  AW  window origin row for current `rd`.
- win_col  out  AW  window origin column for current `rd`.
- wr  out  1  result write strobe to output memory.
- wr_row  out  AW  output row for current `wr`.
- wr_col  out  AW  output column for current `wr`.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle end-of-frame pulse.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; read counters, write counters and valid shift register cleared.
  - All outputs 0 in the following cycle.
  - Reset mid-frame abandons the frame: no further `wr`, no `done`.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start`=1 at an edge -> RUN. Read and write counters are 0 on entry.
  - RUN: rd = !hold (combinational). win_row/win_col = read counters, combinational from registers.
    - At each edge with rd=1 the column increments; at column IMG_W-1 it wraps to 0 and the row increments.
    - rd=1 at (IMG_H-1, IMG_W-1) -> DRAIN; counters return to 0.
    - hold=1 stalls the counters and the state.
  - DRAIN: rd=0; hold ignored. When the valid shift register is all zero -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE. A `start` seen in DONE is ignored.
- busy = (state==RUN || state==DRAIN). `start` while busy or in DONE has no effect.
- Valid pipeline: PIPE_LAT-bit shift register. Bit 0 <= rd; wr = bit PIPE_LAT-1.
  - Consequence: `wr` is high exactly PIPE_LAT cycles after each `rd`, independent of `hold`.
  - Bubbles caused by `hold` propagate unchanged to `wr`.
- Write counters (wr_row, wr_col): registered; advance at each edge with wr=1 using the same wrap rule as the read counters.
  - After the last write both counters read 0.
- Counts: exactly IMG_W*IMG_H `rd` and IMG_W*IMG_H `wr` per frame.
- Timing, no hold, start seen at the edge ending cycle 0:
  - rd high cycles 1..N, where N = IMG_W*IMG_H.
  - wr high cycles 1+PIPE_LAT..N+PIPE_LAT.
  - done high at cycle N+PIPE_LAT+2.
  - busy high cycles 1..N+PIPE_LAT+1.
- Simultaneous events:
  - rst dominates start and hold.
  - hold rising in the same cycle as the final rd has no effect on that rd; rd is already decided by hold in that cycle.
- No arithmetic overflow: counters compare against IMG_W-1 and IMG_H-1 before increment; never exceed the limit.

Test Plan:
1. Reset/idle, IMG_W=4 IMG_H=3 PIPE_LAT=2: rst 3 cycles, then idle 5 cycles -> rd, wr, busy, done all 0; all addresses 0.
2. Basic frame, same params, start at cycle 0:
   - rd cycles 1..12 with (row,col) sequence (0,0),(0,1)..(0,3),(1,0)..(2,3).
   - wr cycles 3..14 with the same address sequence.
   - done only at cycle 16; busy cycles 1..15.
3. Hold: hold=1 in cycles 3-4 of case 2:
   - rd low in cycles 3-4; address (0,2) held and then issued at cycle 5.
   - wr low in cycles 5-6; done at cycle 18; still 12 rd and 12 wr.
4. Start while busy: pulse start at cycle 6 and in the DONE cycle -> no restart; exactly one frame; busy low after done.
5. Reset mid-frame: rst at cycle 7 -> from cycle 8 rd=wr=busy=0, no done. A following start runs a full clean frame beginning at (0,0).
6. Default params (64x64, PIPE_LAT=3):
   - 4096 rd and 4096 wr observed.
   - Last wr at cycle 4099 with wr_row=wr_col=63.
   - done at cycle 4101; back-to-back start in cycle 4102 begins a new frame at cycle 4103.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
// ----------------------------------------------------------------------------
// Frame sequencer for a 3x3 sliding-window line memory and the fixed-latency
// filter pipeline behind it. On start it walks every window origin in raster
// order, issuing rd with the origin row/column. A PIPE_LAT-deep valid shift
// register tracks in-flight pixels. When each result emerges, the module
// asserts wr with the matching output row/column. A single done pulse follows
// once the pipeline has drained.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin one frame (only honoured in IDLE)
//   hold     in   pause read issue (downstream back-pressure)
//   rd       out  window read strobe to line memory
//   win_row  out  [AW-1:0] window origin row for the current rd
//   win_col  out  [AW-1:0] window origin column for the current rd
//   wr       out  result write strobe to output memory
//   wr_row   out  [AW-1:0] output row for the current wr
//   wr_col   out  [AW-1:0] output column for the current wr
//   busy     out  high while reading or draining
//   done     out  one-cycle end-of-frame pulse
// ----------------------------------------------------------------------------
module conv_window_ctrl #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int AW       = 7,
    parameter int PIPE_LAT = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          rd,
    output logic [AW-1:0] win_row,
    output logic [AW-1:0] win_col,
    output logic          wr,
    output logic [AW-1:0] wr_row,
    output logic [AW-1:0] wr_col,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
    localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 1);

    state_t                state_reg;
    logic [AW-1:0]         rd_row_reg;
    logic [AW-1:0]         rd_col_reg;
    logic [AW-1:0]         wr_row_reg;
    logic [AW-1:0]         wr_col_reg;
    logic [PIPE_LAT-1:0]   valid_reg;

    // The read strobe is decided by hold in the same cycle. As a result, a
    // stall costs no extra latency, and hold rising together with the final
    // read only affects later cycles.
    assign rd      = (state_reg == S_RUN) && !hold;
    assign win_row = rd_row_reg;
    assign win_col = rd_col_reg;
    assign wr      = valid_reg[PIPE_LAT-1];
    assign wr_row  = wr_row_reg;
    assign wr_col  = wr_col_reg;
    assign busy    = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done    = (state_reg == S_DONE);

    // Sequencer and read-address counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            rd_row_reg <= '0;
            rd_col_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    rd_row_reg <= '0;
                    rd_col_reg <= '0;
                    if (start) begin
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (rd) begin
                        if (rd_col_reg == COL_LAST) begin
                            rd_col_reg <= '0;
                            if (rd_row_reg == ROW_LAST) begin
                                rd_row_reg <= '0;
                                state_reg  <= S_DRAIN;
                            end else begin
                                rd_row_reg <= rd_row_reg + 1'b1;
                            end
                        end else begin
                            rd_col_reg <= rd_col_reg + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Finish only when no read is still in flight.
                    if (valid_reg == '0) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Valid pipeline: bit 0 captures rd, and each later stage copies its
    // predecessor. Hold bubbles therefore reach wr unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg[0] <= 1'b0;
        end else begin
            valid_reg[0] <= rd;
        end
    end

    generate
        for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                end
            end
        end
    endgenerate

    // Write-address counters follow the same raster wrap as the reads. They
    // land back on (0,0) after the final write, ready for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_row_reg <= '0;
            wr_col_reg <= '0;
        end else if (wr) begin
            if (wr_col_reg == COL_LAST) begin
                wr_col_reg <= '0;
                if (wr_row_reg == ROW_LAST) begin
                    wr_row_reg <= '0;
                end else begin
                    wr_row_reg <= wr_row_reg + 1'b1;
                end
            end else begin
                wr_col_reg <= wr_col_reg + 1'b1;
            end
        end
    end

endmodule
